// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 serial receiver: register addresses,
// receiver state encoding and the frame-length check.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT8    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_COMMIT    = 2'd3
    } rx_state_t;

    // Strict mode accepts exactly FRAME_BITS; relaxed mode keeps the last 16 of a longer frame.
    function automatic logic frame_len_ok(input logic [4:0] cnt, input logic strict);
        logic ok;
        if (strict) begin
            ok = (cnt == 5'(FRAME_BITS));
        end else begin
            ok = (cnt >= 5'(FRAME_BITS));
        end
        return ok;
    endfunction

endpackage

// File: rtl/max7219_in_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by a
// previous-value flop from which rise/fall pulses are decoded.
module max7219_in_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer chain and edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 serial-side emulator: oversamples cs/clk/din, shifts 16-bit frames,
// commits them into the register image and forwards shifted data on dout.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STRICT_LEN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_cs,
    input  logic        io_clk,
    input  logic        io_din,
    output logic        dout,
    output logic [63:0] digit_seg,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        word_valid,
    output logic [15:0] word_data,
    output logic        frame_err
);

    // The reset value of cs_s is 1, so WAIT_IDLE must let the whole chain
    // refill before it can trust a high cs; otherwise a frame in flight at
    // reset release would look like a fresh cs fall.
    localparam logic [7:0] FLUSH_CYCLES = 8'(SYNC_STAGES + 1);

    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_din_s, w_din_rise, w_din_fall;
    logic w_unused;

    rx_state_t   r_state, w_next;
    logic [7:0]  r_flush_cnt;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        w_shift_en, w_dout_en, w_commit_ok, w_commit_bad;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [2:0]  w_digit_idx;

    max7219_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(io_cs),
        .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Data path runs one stage behind cs so a bit is never sampled ahead of its frame start.
    max7219_in_sync #(.STAGES(SYNC_STAGES + 1), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(io_clk),
        .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    max7219_in_sync #(.STAGES(SYNC_STAGES + 1), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .i_async(io_din),
        .o_sync(w_din_s), .o_rise(w_din_rise), .o_fall(w_din_fall)
    );

    assign w_unused = ^{w_sclk_s, w_din_rise, w_din_fall};

    assign w_shift_en   = (r_state == ST_SHIFT) && w_sclk_rise && !w_cs_s;
    assign w_dout_en    = (r_state == ST_SHIFT) && w_sclk_fall && !w_cs_s;
    assign w_commit_ok  = (r_state == ST_COMMIT) && frame_len_ok(r_bit_cnt, STRICT_LEN != 0);
    assign w_commit_bad = (r_state == ST_COMMIT) && !frame_len_ok(r_bit_cnt, STRICT_LEN != 0);
    assign w_addr       = r_shift[11:8];
    assign w_data       = r_shift[7:0];
    assign w_digit_idx  = 3'(w_addr - 4'd1);

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_cs_s && (r_flush_cnt == FLUSH_CYCLES)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_next = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_next = ST_COMMIT;
                end else begin
                    w_next = ST_SHIFT;
                end
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_WAIT_IDLE;
        endcase
    end

    // Shift register, bit counter, daisy-chain output and commit pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= 8'd0;
            r_shift     <= 16'd0;
            r_bit_cnt   <= 5'd0;
            dout        <= 1'b0;
            word_valid  <= 1'b0;
            word_data   <= 16'd0;
            frame_err   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if ((r_state == ST_WAIT_IDLE) && (r_flush_cnt != FLUSH_CYCLES)) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 5'd0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[14:0], w_din_s};
                if (r_bit_cnt != 5'd31) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            if (w_dout_en) begin
                dout <= r_shift[15];
            end
            if (w_commit_ok) begin
                word_valid <= 1'b1;
                word_data  <= r_shift;
            end
            if (w_commit_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Register image, written only by a committed valid frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_seg    <= 64'd0;
            decode_mode  <= 8'd0;
            intensity    <= 4'd0;
            scan_limit   <= 3'd0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
        end else if (w_commit_ok) begin
            case (w_addr)
                ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3, ADDR_DIGIT4,
                ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7, ADDR_DIGIT8:
                    digit_seg[{w_digit_idx, 3'b000} +: 8] <= w_data;
                ADDR_DECODE:    decode_mode  <= w_data;
                ADDR_INTENSITY: intensity    <= w_data[3:0];
                ADDR_SCANLIM:   scan_limit   <= w_data[2:0];
                ADDR_SHUTDOWN:  shutdown_n   <= w_data[0];
                ADDR_TEST:      display_test <= w_data[0];
                default: ;
            endcase
        end
    end

endmodule
